// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stage write enables, bubble strobes, halt and a saturating stall counter.
// Build option: define HAZ_FORWARD_EN when EX/MEM and MEM/WB forwarding paths exist (load-use stall only).
module pipe_hazard_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       id_rd_reg_1,
   input  logic [2:0]       id_rd_reg_2,
   input  logic             id_rd_en_1,
   input  logic             id_rd_en_2,
   input  logic [2:0]       ex_wr_reg,
   input  logic             ex_wr_en,
   input  logic             ex_mem_rd,
   input  logic [2:0]       mem_wr_reg,
   input  logic             mem_wr_en,
   input  logic [2:0]       wb_wr_reg,
   input  logic             wb_wr_en,
   input  logic             take_new_PC,
   input  logic             imem_stall,
   input  logic             dmem_stall,
   input  logic             halt_in,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             err
);

   typedef enum logic [1:0] {RUN, DSTALL, HALT} state_t;

   state_t state, state_nxt;
   logic   hit_ex, hit_mem, hit_wb, raw_haz;

   function automatic logic hit(input logic [2:0] r,
                                input logic [2:0] s1, input logic e1,
                                input logic [2:0] s2, input logic e2);
      return (e1 && (s1 == r)) || (e2 && (s2 == r));
   endfunction

   assign hit_ex  = hit(ex_wr_reg,  id_rd_reg_1, id_rd_en_1, id_rd_reg_2, id_rd_en_2);
   assign hit_mem = hit(mem_wr_reg, id_rd_reg_1, id_rd_en_1, id_rd_reg_2, id_rd_en_2);
   assign hit_wb  = hit(wb_wr_reg,  id_rd_reg_1, id_rd_en_1, id_rd_reg_2, id_rd_en_2);

`ifdef HAZ_FORWARD_EN
   assign raw_haz = ex_wr_en && ex_mem_rd && hit_ex;
`else
   assign raw_haz = (ex_wr_en && hit_ex) || (mem_wr_en && hit_mem) || (wb_wr_en && hit_wb);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= RUN;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      {if_id_flush, id_ex_flush, mem_wb_flush}          = '0;
      halted = 1'b0;

      unique case (state)
         RUN, DSTALL: state_nxt = dmem_stall ? DSTALL : RUN;
         default:     state_nxt = HALT;
      endcase
      if (halt_in) state_nxt = HALT;

      // Decode is gated by reset so every strobe is quiet while rst is low.
      if (rst) begin
         if (state == HALT) begin
            halted = 1'b1;
         end else if (dmem_stall) begin
            mem_wb_en    = 1'b1;
            mem_wb_flush = 1'b1;
         end else if (take_new_PC) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (raw_haz) begin
            {id_ex_en, ex_mem_en, mem_wb_en} = '1;
            id_ex_flush = 1'b1;
         end else if (imem_stall) begin
            {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
            if_id_flush = 1'b1;
         end else begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cycles <= '0;
      else if (!pc_en && (state != HALT) && (stall_cycles != '1))
         stall_cycles <= stall_cycles + 1'b1;
   end

   always_comb begin
      err = ((^{rst, id_rd_reg_1, id_rd_reg_2, id_rd_en_1, id_rd_en_2,
                ex_wr_reg, ex_wr_en, ex_mem_rd, mem_wr_reg, mem_wr_en,
                wb_wr_reg, wb_wr_en, take_new_PC, imem_stall, dmem_stall,
                halt_in}) === 1'bx);
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized self-checking bench for pipe_hazard_ctrl against a rule-level model, plus directed scenarios.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] id_rd_reg_1, id_rd_reg_2, ex_wr_reg, mem_wr_reg, wb_wr_reg;
   logic       id_rd_en_1, id_rd_en_2, ex_wr_en, ex_mem_rd, mem_wr_en, wb_wr_en;
   logic       take_new_PC, imem_stall, dmem_stall, halt_in;

   logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic        if_id_flush, id_ex_flush, mem_wb_flush, halted, err;
   logic [15:0] stall_cycles;
   logic [8:0]  s_o;
   logic [3:0]  s_cnt;
   logic        s_err;

   int unsigned n_pass = 0, n_total = 0;
   int unsigned m_count = 0, m_count_s = 0;
   logic        m_halted = 1'b0;
   logic [8:0]  last_exp;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .id_rd_reg_1(id_rd_reg_1), .id_rd_reg_2(id_rd_reg_2),
      .id_rd_en_1(id_rd_en_1), .id_rd_en_2(id_rd_en_2),
      .ex_wr_reg(ex_wr_reg), .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd),
      .mem_wr_reg(mem_wr_reg), .mem_wr_en(mem_wr_en),
      .wb_wr_reg(wb_wr_reg), .wb_wr_en(wb_wr_en),
      .take_new_PC(take_new_PC), .imem_stall(imem_stall),
      .dmem_stall(dmem_stall), .halt_in(halt_in),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
      .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .mem_wb_flush(mem_wb_flush), .halted(halted),
      .stall_cycles(stall_cycles), .err(err)
   );

   // Narrow-counter copy so saturation is reachable in a short run.
   pipe_hazard_ctrl #(.CNT_W(4)) dut_s (
      .clk(clk), .rst(rst),
      .id_rd_reg_1(id_rd_reg_1), .id_rd_reg_2(id_rd_reg_2),
      .id_rd_en_1(id_rd_en_1), .id_rd_en_2(id_rd_en_2),
      .ex_wr_reg(ex_wr_reg), .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd),
      .mem_wr_reg(mem_wr_reg), .mem_wr_en(mem_wr_en),
      .wb_wr_reg(wb_wr_reg), .wb_wr_en(wb_wr_en),
      .take_new_PC(take_new_PC), .imem_stall(imem_stall),
      .dmem_stall(dmem_stall), .halt_in(halt_in),
      .pc_en(s_o[8]), .if_id_en(s_o[7]), .id_ex_en(s_o[6]),
      .ex_mem_en(s_o[5]), .mem_wb_en(s_o[4]),
      .if_id_flush(s_o[3]), .id_ex_flush(s_o[2]),
      .mem_wb_flush(s_o[1]), .halted(s_o[0]),
      .stall_cycles(s_cnt), .err(s_err)
   );

   function automatic logic [8:0] dut_out();
      return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
              if_id_flush, id_ex_flush, mem_wb_flush, halted};
   endfunction

   function automatic logic model_raw();
      logic [2:0] wr[3];
      logic       we[3];
      int unsigned n_prod;
      logic r = 1'b0;
      wr[0] = ex_wr_reg;  wr[1] = mem_wr_reg; wr[2] = wb_wr_reg;
`ifdef HAZ_FORWARD_EN
      we[0] = ex_wr_en && ex_mem_rd; we[1] = 1'b0; we[2] = 1'b0;
      n_prod = 1;
`else
      we[0] = ex_wr_en; we[1] = mem_wr_en; we[2] = wb_wr_en;
      n_prod = 3;
`endif
      for (int unsigned i = 0; i < n_prod; i++)
         if (we[i] && ((id_rd_en_1 && id_rd_reg_1 == wr[i]) || (id_rd_en_2 && id_rd_reg_2 == wr[i])))
            r = 1'b1;
      return r;
   endfunction

   // {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id/id_ex/mem_wb flushes, halted}
   function automatic logic [8:0] model_out();
      if (!rst)        return 9'b00000_000_0;
      if (m_halted)    return 9'b00000_000_1;
      if (dmem_stall)  return 9'b00001_001_0;
      if (take_new_PC) return 9'b11111_110_0;
      if (model_raw()) return 9'b00111_010_0;
      if (imem_stall)  return 9'b01111_100_0;
      return 9'b11111_000_0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic clear_inputs();
      {id_rd_reg_1, id_rd_reg_2, ex_wr_reg, mem_wr_reg, wb_wr_reg} = '0;
      {id_rd_en_1, id_rd_en_2, ex_wr_en, ex_mem_rd, mem_wr_en, wb_wr_en} = '0;
      {take_new_PC, imem_stall, dmem_stall, halt_in} = '0;
   endtask

   // Compare on the falling edge, then advance the model across the rising edge.
   task automatic step();
      logic [8:0] exp;
      @(negedge clk);
      if (!rst) begin
         m_halted = 1'b0; m_count = 0; m_count_s = 0;
      end
      exp = model_out();
      last_exp = exp;
      check("outs", {23'd0, dut_out()}, {23'd0, exp});
      check("outs_s", {23'd0, s_o}, {23'd0, exp});
      check("stall_cycles", {16'd0, stall_cycles}, m_count);
      check("stall_cycles_s", {28'd0, s_cnt}, m_count_s);
      check("err", {31'd0, err}, 32'd0);
      @(posedge clk);
      if (rst) begin
         if (!exp[8] && !m_halted) begin
            if (m_count < 32'hFFFF) m_count++;
            if (m_count_s < 15) m_count_s++;
         end
         if (halt_in) m_halted = 1'b1;
      end
      #1;
   endtask

   task automatic raw_seq(input logic is_load, input logic [2:0] r, input int unsigned exp_stalls);
      logic waiting = 1'b1;
      logic [15:0] c0 = stall_cycles;
      for (int k = 0; k < 5; k++) begin
         clear_inputs();
         id_rd_reg_1 = r;
         id_rd_en_1  = waiting;
         id_rd_reg_2 = r + 3'd1;
         if (k == 0)      begin ex_wr_reg = r;  ex_wr_en = 1'b1; ex_mem_rd = is_load; end
         else if (k == 1) begin mem_wr_reg = r; mem_wr_en = 1'b1; end
         else if (k == 2) begin wb_wr_reg = r;  wb_wr_en = 1'b1; end
         step();
         if (last_exp[8]) waiting = 1'b0;
      end
      check(is_load ? "load_use_stalls" : "alu_raw_stalls", {16'd0, stall_cycles - c0}, exp_stalls);
   endtask

   initial begin
      logic [15:0] c0;
      clear_inputs();
      rst = 1'b0;
      #1;
      check("reset_outs", {23'd0, dut_out()}, 32'd0);
      check("reset_cnt", {16'd0, stall_cycles}, 32'd0);
      step(); step();
      rst = 1'b1;
      step();

`ifdef HAZ_FORWARD_EN
      raw_seq(1'b1, 3'd3, 1);
      raw_seq(1'b0, 3'd5, 0);
`else
      raw_seq(1'b1, 3'd3, 3);
      raw_seq(1'b0, 3'd5, 3);
`endif

      // Redirect overrides both a RAW hit and an instruction-fetch stall.
      clear_inputs();
      c0 = stall_cycles;
      take_new_PC = 1'b1; imem_stall = 1'b1;
      ex_wr_reg = 3'd2; ex_wr_en = 1'b1; ex_mem_rd = 1'b1;
      id_rd_reg_2 = 3'd2; id_rd_en_2 = 1'b1;
      #1;
      check("redirect_outs", {23'd0, dut_out()}, {23'd0, 9'b11111_110_0});
      step();
      check("redirect_no_stall", {16'd0, stall_cycles - c0}, 32'd0);

      clear_inputs();
      c0 = stall_cycles;
      dmem_stall = 1'b1;
      #1;
      check("dmem_outs", {23'd0, dut_out()}, {23'd0, 9'b00001_001_0});
      repeat (4) step();
      dmem_stall = 1'b0;
      step();
      check("dmem_stall_cnt", {16'd0, stall_cycles - c0}, 32'd4);

      clear_inputs();
      halt_in = 1'b1;
      step();
      halt_in = 1'b0;
      c0 = stall_cycles;
      imem_stall = 1'b1; take_new_PC = 1'b1;
      repeat (5) step();
      check("halted", {31'd0, halted}, 32'd1);
      check("halt_pc_en", {31'd0, pc_en}, 32'd0);
      check("halt_cnt_frozen", {16'd0, stall_cycles - c0}, 32'd0);
      rst = 1'b0;
      step();
      rst = 1'b1;
      clear_inputs();
      #1;
      check("rearm_halted", {31'd0, halted}, 32'd0);
      check("rearm_cnt", {16'd0, stall_cycles}, 32'd0);

      imem_stall = 1'b1;
      repeat (20) step();
      check("sat_small", {28'd0, s_cnt}, 32'hF);
      check("imem_cnt", {16'd0, stall_cycles}, 32'd20);

      for (int n = 0; n < 3000; n++) begin
         id_rd_reg_1 = 3'($urandom); id_rd_reg_2 = 3'($urandom);
         ex_wr_reg   = 3'($urandom); mem_wr_reg  = 3'($urandom);
         wb_wr_reg   = 3'($urandom);
         id_rd_en_1  = 1'($urandom); id_rd_en_2  = 1'($urandom);
         ex_wr_en    = 1'($urandom); ex_mem_rd   = 1'($urandom);
         mem_wr_en   = 1'($urandom); wb_wr_en    = 1'($urandom);
         take_new_PC = ($urandom_range(7) == 0);
         imem_stall  = ($urandom_range(3) == 0);
         dmem_stall  = ($urandom_range(5) == 0);
         halt_in     = ($urandom_range(249) == 0);
         rst         = ($urandom_range(149) != 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage processor. It generates the per-stage register write enables and bubble (flush) strobes for IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves RAW load-use hazards, branch/jump redirects, instruction- and data-memory stalls and halt. It also keeps a saturating stall-cycle counter. It sits beside the pipeline registers and drives their `writeEn`; the flush strobes zero the control fields of the receiving register.

## Interface
Parameters:
- `CNT_W`, 16, width of `stall_cycles` counter

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `id_rd_reg_1`, `id_rd_reg_2`  in  3 each  source registers of the instruction in ID
- `id_rd_en_1`, `id_rd_en_2`  in  1 each  the corresponding source is actually read
- `ex_wr_reg`  in  3; `ex_wr_en`  in  1; `ex_mem_rd`  in  1  destination, write-enable and is-load of the instruction in EX
- `mem_wr_reg`  in  3; `mem_wr_en`  in  1  destination and write-enable of the instruction in MEM
- `wb_wr_reg`  in  3; `wb_wr_en`  in  1  destination and write-enable of the instruction in WB
- `take_new_PC`  in  1  branch/jump redirect resolved in EX
- `imem_stall`  in  1  instruction fetch not complete this cycle
- `dmem_stall`  in  1  data memory busy; the MEM stage cannot complete
- `halt_in`  in  1  halt instruction is in WB
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1 each  register write enables
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush`  out  1 each  load a bubble into that register
- `halted`  out  1  processor halted
- `stall_cycles`  out  `CNT_W`  saturating count of stalled cycles
- `err`  out  1  any input is X/Z

## Operation
- FSM states are RUN, DSTALL and HALT. Reset state is RUN.
- Transitions:
  - RUN→DSTALL when `dmem_stall`=1 at the clock edge.
  - DSTALL→RUN when `dmem_stall`=0.
  - Any state→HALT when `halt_in`=1 at the clock edge.
  - HALT is sticky until `rst` is low.
- Hazard match: `hit(r) = (id_rd_en_1 & id_rd_reg_1==r) | (id_rd_en_2 & id_rd_reg_2==r)`.
- Outputs are a combinational priority decode, highest priority first:
  1. HALT: all `*_en`=0, all flushes=0, `halted`=1.
  2. `dmem_stall`=1: `pc_en`..`ex_mem_en`=0; `mem_wb_en`=1 with `mem_wb_flush`=1.
  3. `take_new_PC`=1: all enables=1, `if_id_flush`=1, `id_ex_flush`=1. The redirect overrides a RAW hazard and `imem_stall`.
  4. RAW hazard: `pc_en`=0, `if_id_en`=0, `id_ex_en`=1 with `id_ex_flush`=1, later stages enabled.
  5. `imem_stall`=1: `pc_en`=0, `if_id_en`=1 with `if_id_flush`=1, later stages enabled.
  6. Otherwise all enables=1, all flushes=0.
- The `dmem_stall` decode (priority 2) applies combinationally in both RUN and DSTALL. DSTALL is used only for counting and observability.
- `stall_cycles` increments on every clock edge where `pc_en`=0, state≠HALT and `rst`=1. It saturates at all-ones and does not wrap.
- `err` = reduction-XOR of all inputs `=== 1'bX`; it is combinational.

## Timing
- Enables and flushes are combinational from same-cycle inputs. Pipeline registers sample them at the next rising edge, so there is zero-cycle latency.
- RAW stalls last until the producer leaves the hazard window. The length depends on `HAZ_FORWARD_EN` (see Configuration).
- HALT takes effect the cycle after `halt_in` is sampled. The halting instruction's WB completes normally.
- `halt_in` in the same cycle as `dmem_stall`: HALT is entered at the edge and wins from then on.
- While `rst`=0: state is RUN, `halted`=0, `stall_cycles`=0, all `*_en`=0, all flushes=0.
- Deassertion of `rst` mid-stall: the controller resumes in RUN and decodes from the current inputs.

## Configuration
- `HAZ_FORWARD_EN` defined (EX/MEM and MEM/WB forwarding paths present):
  - RAW hazard = `ex_wr_en & ex_mem_rd & hit(ex_wr_reg)`.
  - This is a load-use stall of exactly 1 cycle.
- `HAZ_FORWARD_EN` undefined (no forwarding; the register file is not write-through):
  - RAW hazard = `(ex_wr_en & hit(ex_wr_reg)) | (mem_wr_en & hit(mem_wr_reg)) | (wb_wr_en & hit(wb_wr_reg))`.
  - Stalls last up to 3 cycles.

## Test plan
- Load r3 in EX, ID reads r3 on port 1 (forwarding on): exactly 1 cycle of `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1; then all enables=1; `stall_cycles`=1.
- Same stream with `HAZ_FORWARD_EN` off, ALU writing r5 followed by a reader of r5: 3 consecutive stall cycles, then proceed; `stall_cycles`=3.
- `take_new_PC`=1 together with a RAW hit and `imem_stall`=1: `if_id_flush`=`id_ex_flush`=1, `pc_en`=1, no stall counted.
- `dmem_stall` high for 4 cycles: `pc_en`..`ex_mem_en`=0 and `mem_wb_flush`=1 for 4 cycles; state is DSTALL from the edge after the first `dmem_stall` cycle through the edge after it drops; `stall_cycles`+=4.
- `halt_in`=1 for one cycle: from the next cycle all enables=0 and `halted`=1 indefinitely; `stall_cycles` frozen; `rst` low→high returns to RUN with the count at 0.
- Force the counter to 16'hFFFE and hold `imem_stall`=1 for 5 cycles: the counter reads 16'hFFFF and stays there.
